// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit-side blocks inside UART_AHB.
//   - FSM state encodings for the TX arbiter (IDLE / START / WAIT_DONE)
//   - default byte width and default watchdog length
//   - helper to size a counter that must hold a given maximum count
// No ports: this is a package.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_TIMEOUT_CYC = 4096;

    // Width that can represent every value 0..maxCount inclusive, so the
    // watchdog counter can step one past its abort point without wrapping.
    function automatic int cntWidth(input int maxCount);
        return $clog2(maxCount + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick among NUM_REQ requesters. The search
// starts at the requester after the last one granted and wraps, so the most
// recently served requester has the lowest priority on the next round.
// Ports:
//   i_valid      NUM_REQ  per-requester request
//   i_last_grant ID_W     index granted most recently
//   i_enable     1        when low, no grant is produced
//   o_grant      NUM_REQ  one-hot winner (all zero if none)
//   o_grant_idx  ID_W     encoded winner (0 when no winner)
// ---------------------------------------------------------------------------
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]    i_last_grant,
    input  logic               i_enable,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_idx
);

    logic [ID_W-1:0] w_idx;
    logic            w_found;

    // Walk the requesters in rotated order (last+1, last+2, ... wrapping
    // modulo NUM_REQ, ending on last itself) and keep the first valid one.
    // The modulo keeps the rotated index legal for non-power-of-two counts.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_idx       = '0;
        w_found     = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_idx = ID_W'((int'(i_last_grant) + off) % NUM_REQ);
            if (i_enable && !w_found && i_valid[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares the single UART transmitter between NUM_REQ byte sources. One byte
// is accepted per grant, handed to the transmitter with a one-cycle start
// pulse, and the block then waits for the transmitter's done pulse. A
// watchdog aborts the wait after TIMEOUT_CYC cycles, drops the byte and
// raises a sticky interrupt.
// Ports:
//   HCLK / HRESETn  clock / async reset, active HIGH despite the legacy name
//   i_enable        permits new grants
//   i_req_valid     per-requester byte valid
//   i_req_data      requester k byte at [k*DATA_W +: DATA_W]
//   o_req_ready     one-hot accept, a transfer happens on valid & ready
//   o_tx_start      one-cycle start pulse to the transmitter
//   o_tx_data       byte being sent, stable from START until back in IDLE
//   i_tx_busy       transmitter still shifting a previous byte
//   i_tx_done       one-cycle completion pulse from the transmitter
//   o_grant_id      index of the last granted requester
//   o_busy          high whenever the FSM is not in IDLE
//   o_timeout_irq   sticky watchdog flag
//   i_irq_clr       clears o_timeout_irq
// ID_W must equal clog2(NUM_REQ).
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ID_W        = 1,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      i_enable,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_tx_start,
    output logic [DATA_W-1:0]         o_tx_data,
    input  logic                      i_tx_busy,
    input  logic                      i_tx_done,
    output logic [ID_W-1:0]           o_grant_id,
    output logic                      o_busy,
    output logic                      o_timeout_irq,
    input  logic                      i_irq_clr
);

    localparam int                CNT_W    = cntWidth(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [ID_W-1:0]   LAST_RST = ID_W'(NUM_REQ - 1);

    logic [1:0]          r_state;
    logic [DATA_W-1:0]   r_tx_data;
    logic [ID_W-1:0]     r_last_grant;
    logic [CNT_W-1:0]    r_wd_cnt;
    logic                r_timeout_irq;

    logic                w_arb_en;
    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_grant_idx;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_start_fire;
    logic                w_timeout;

    // Grants are only offered from IDLE, so ready can never assert while a
    // byte is in flight even if i_enable stays high.
    assign w_arb_en = i_enable && (r_state == ST_IDLE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .i_valid      (i_req_valid),
        .i_last_grant (r_last_grant),
        .i_enable     (w_arb_en),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx)
    );

    // Pick the winner's byte with the one-hot grant; an AND-OR mux avoids a
    // variable part-select on the encoded index.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant[k]) begin
                w_sel_data = w_sel_data | i_req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // The start pulse is decoded from state so it is exactly one cycle wide
    // and falls immediately when reset forces the state back to IDLE.
    // A done pulse on the abort cycle wins, so the watchdog only fires
    // when done is absent.
    assign w_start_fire = (r_state == ST_START) && !i_tx_busy;
    assign w_timeout    = (r_state == ST_WAIT_DONE) && !i_tx_done && (r_wd_cnt == CNT_LAST);

    // Main FSM with the byte latch, grant history and watchdog counter.
    // The counter is cleared on entry to WAIT_DONE and counts every cycle
    // spent there; i_tx_done is deliberately ignored while in START.
    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            r_state      <= ST_IDLE;
            r_tx_data    <= '0;
            r_last_grant <= LAST_RST;
            r_wd_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_tx_data    <= w_sel_data;
                        r_last_grant <= w_grant_idx;
                        r_state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (!i_tx_busy) begin
                        r_wd_cnt <= '0;
                        r_state  <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    r_wd_cnt <= r_wd_cnt + CNT_W'(1);
                    if (i_tx_done || w_timeout) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky watchdog interrupt. A new timeout takes priority over a clear
    // arriving in the same cycle so an abort is never silently lost.
    always_ff @(posedge HCLK or posedge HRESETn) begin
        if (HRESETn) begin
            r_timeout_irq <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_irq <= 1'b1;
        end else if (i_irq_clr) begin
            r_timeout_irq <= 1'b0;
        end
    end

    assign o_req_ready   = w_grant;
    assign o_tx_start    = w_start_fire;
    assign o_tx_data     = r_tx_data;
    assign o_grant_id    = r_last_grant;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_timeout_irq = r_timeout_irq;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares the single UART transmitter between NUM_REQ byte requesters, e.g. the AHB TX FIFO drain and an on-chip status/debug source.
- Accepts one byte per grant and issues a one-cycle start pulse to the transmitter.
- Waits for transmit completion, guarded by a watchdog.
- Sits between the requesters and the UART TX/baud datapath inside UART_AHB.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_W, 8, byte width
ID_W, 1, grant index width; must equal clog2(NUM_REQ)
TIMEOUT_CYC, 4096, max HCLK cycles in WAIT_DONE before abort

Ports:
HCLK  in  1  clock
HRESETn  in  1  reset; asynchronous, active-high (1 = reset)
i_enable  in  1  permits new grants
i_req_valid  in  NUM_REQ  per-requester byte valid
i_req_data  in  NUM_REQ*DATA_W  requester k byte at [k*DATA_W +: DATA_W]
o_req_ready  out  NUM_REQ  one-hot accept; transfer when valid&ready
o_tx_start  out  1  one-cycle start pulse to transmitter
o_tx_data  out  DATA_W  byte held stable from START until return to IDLE
i_tx_busy  in  1  transmitter shifting
i_tx_done  in  1  one-cycle completion pulse
o_grant_id  out  ID_W  index of last granted requester
o_busy  out  1  state != IDLE
o_timeout_irq  out  1  sticky watchdog flag
i_irq_clr  in  1  clears o_timeout_irq

Behaviour:
- Reset values:
  - state=IDLE, o_tx_start=0, o_tx_data=0, o_req_ready=0, o_busy=0, o_timeout_irq=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority; o_grant_id=NUM_REQ-1; watchdog counter=0.
- States: IDLE, START, WAIT_DONE.
- IDLE:
  - o_req_ready is combinational, asserted only when i_enable=1 and any valid=1.
  - The one-hot winner is the first valid index searched from last_grant+1, wrapping modulo NUM_REQ.
  - On that edge: latch the winner's byte into o_tx_data; last_grant and o_grant_id take the winner; go to START.
- START:
  - While i_tx_busy=1: o_tx_start=0, stay in START.
  - When i_tx_busy=0: o_tx_start=1 for exactly this cycle; next state WAIT_DONE; counter cleared.
  - i_tx_done is ignored in START.
- WAIT_DONE:
  - The counter increments every cycle.
  - On i_tx_done=1: go to IDLE.
  - When the counter reaches TIMEOUT_CYC-1 with no done: set o_timeout_irq; go to IDLE; the byte is dropped and not retried.
  - If done and timeout occur in the same cycle, done wins and no irq is raised.
- Latency:
  - Grant edge to o_tx_start high: 1 cycle if not busy.
  - i_tx_done to next grant possible: 1 cycle (the IDLE cycle).
  - Back-to-back throughput: one byte per transmit time + 2 cycles.
- i_enable=0:
  - No new grants; o_req_ready=0.
  - An in-flight byte runs to done or timeout.
- Fairness: two requesters valid continuously alternate grants 0,1,0,1. A single valid requester is granted every round.
- o_timeout_irq:
  - Set has priority over i_irq_clr in the same cycle.
  - Otherwise i_irq_clr clears it the next edge.
- Reset asserted mid-operation: immediate return to reset values; any latched byte is lost; o_tx_start drops asynchronously.
- The counter width holds TIMEOUT_CYC; no wrap in normal operation.

Decomposition:
- Shared package uart_pkg: state encoding constants (IDLE/START/WAIT_DONE), default DATA_W=8, default TIMEOUT_CYC.
- Sub-module rr_arbiter (combinational), parameterised on NUM_REQ:
  - Inputs: valid vector, last_grant, enable.
  - Outputs: one-hot grant and encoded index.
- The FSM, data latch and watchdog stay in uart_tx_arbiter.

Test Plan:
1. Reset then single request: HRESETn 1→0; req0 valid, data=0xAB, busy=0.
   → ready[0] high 1 cycle; o_tx_start pulses the next cycle with o_tx_data=0xAB; o_grant_id=0; after done pulse o_busy=0.
2. Both requesters continuously valid (req0=0x11, req1=0x22), done returned 20 cycles after each start.
   → o_tx_data sequence 0x11,0x22,0x11,0x22; exactly one start per done.
3. i_tx_busy held high 5 cycles after the grant.
   → o_tx_start stays 0 for those 5 cycles, then pulses once on the first busy=0 cycle.
4. Watchdog: TIMEOUT_CYC=16, no i_tx_done.
   → o_timeout_irq rises 16 cycles after start; state returns to IDLE; i_irq_clr clears it the next cycle. Clear coincident with a new timeout keeps irq=1.
5. i_enable=0 mid-transfer with requests pending.
   → current byte completes on done; no ready asserted until i_enable=1.
6. Reset asserted in WAIT_DONE.
   → o_busy, o_tx_start, o_tx_data drop to 0 immediately; the first post-reset grant goes to req0 even though req1 was last granted.
